// File: rtl/rptr_handler_lvl.sv
// rtl/rptr_handler_lvl.sv - async FIFO read pointer, level, almost-empty and status flags
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_handler_lvl #(
  parameter int PTR_WIDTH = 3
) (
  input  logic                 i_Rclk,
  input  logic                 i_Rrst_n,
  input  logic                 i_R_en,
  input  logic [PTR_WIDTH:0]   i_g_wptr_sync,
  input  logic [PTR_WIDTH:0]   i_ae_thresh,
  input  logic                 i_clr_err,
  output logic [PTR_WIDTH:0]   o_b_rptr,
  output logic [PTR_WIDTH:0]   o_g_rptr,
  output logic [PTR_WIDTH-1:0] o_raddr,
  output logic                 o_empty,
  output logic                 o_rempty,
  output logic                 o_almost_empty,
  output logic [PTR_WIDTH:0]   o_rlevel,
  output logic                 o_rd_ack,
  output logic                 o_underflow
);

  localparam int PW = PTR_WIDTH + 1;

  logic [PW-1:0] r_b_rptr;
  logic [PW-1:0] r_g_rptr;
  logic [PW-1:0] r_rlevel;
  logic          r_empty;
  logic          r_almost_empty;
  logic          r_rd_ack;

  logic          w_rd_acc;
  logic [PW-1:0] w_b_next;
  logic [PW-1:0] w_g_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_lvl_next;
  logic          w_ae_next;

  assign w_rd_acc   = i_R_en & ~r_empty;
  assign w_b_next   = r_b_rptr + PW'(w_rd_acc);
  assign w_g_next   = (w_b_next >> 1) ^ w_b_next;
  assign o_rempty   = (w_g_next == i_g_wptr_sync);
  assign w_lvl_next = w_wbin - w_b_next;
  // Level never exceeds depth, so a threshold >= depth yields 1 naturally.
  assign w_ae_next  = (w_lvl_next <= i_ae_thresh);

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_wbin[i] = ^(i_g_wptr_sync >> i);
    end
  end

  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_rlevel       <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_ack       <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_next;
      r_g_rptr       <= w_g_next;
      r_rlevel       <= w_lvl_next;
      r_empty        <= o_rempty;
      r_almost_empty <= w_ae_next;
      r_rd_ack       <= w_rd_acc;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic r_underflow;

  // A new underflow takes priority over a clear in the same cycle.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      r_underflow <= 1'b0;
    end else if (i_R_en & r_empty) begin
      r_underflow <= 1'b1;
    end else if (i_clr_err) begin
      r_underflow <= 1'b0;
    end
  end

  assign o_underflow = r_underflow;
`else
  logic w_unused_clr;

  assign w_unused_clr = i_clr_err;
  assign o_underflow  = 1'b0;
`endif

  assign o_b_rptr       = r_b_rptr;
  assign o_g_rptr       = r_g_rptr;
  assign o_raddr        = r_b_rptr[PTR_WIDTH-1:0];
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_rlevel       = r_rlevel;
  assign o_rd_ack       = r_rd_ack;

endmodule

// File: tb/tb_rptr_handler_lvl.sv
// tb/tb_rptr_handler_lvl.sv - directed vector bench for rptr_handler_lvl (PTR_WIDTH=3)
module tb_rptr_handler_lvl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r_en;
  logic [3:0] g_wptr;
  logic [3:0] thresh;
  logic       clr_err;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic [2:0] raddr;
  logic       empty;
  logic       rempty;
  logic       almost_empty;
  logic [3:0] rlevel;
  logic       rd_ack;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rptr_handler_lvl #(.PTR_WIDTH(3)) dut (
    .i_Rclk         (clk),
    .i_Rrst_n       (rst_n),
    .i_R_en         (r_en),
    .i_g_wptr_sync  (g_wptr),
    .i_ae_thresh    (thresh),
    .i_clr_err      (clr_err),
    .o_b_rptr       (b_rptr),
    .o_g_rptr       (g_rptr),
    .o_raddr        (raddr),
    .o_empty        (empty),
    .o_rempty       (rempty),
    .o_almost_empty (almost_empty),
    .o_rlevel       (rlevel),
    .o_rd_ack       (rd_ack),
    .o_underflow    (underflow)
  );

  typedef struct {
    logic       ren;
    logic [3:0] wbin;
    logic [3:0] thr;
    logic       clr;
    logic       x_rempty;
    logic [3:0] x_b;
    logic [3:0] x_g;
    logic       x_e;
    logic       x_ae;
    logic [3:0] x_l;
    logic       x_ack;
    logic       x_uf;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " b_rptr"}, 32'(b_rptr), 0);
    chk({tag, " g_rptr"}, 32'(g_rptr), 0);
    chk({tag, " raddr"}, 32'(raddr), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " almost_empty"}, 32'(almost_empty), 1);
    chk({tag, " rlevel"}, 32'(rlevel), 0);
    chk({tag, " rd_ack"}, 32'(rd_ack), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       uf_exp;
  logic [3:0] wcnt, rcnt, lvl, prev_b, prev_g;
  logic       exp_e, seen_wrap;
  int         wtotal;

  initial begin
    rst_n = 1'b0; r_en = 1'b0; g_wptr = '0; thresh = 4'd2; clr_err = 1'b0;

    //           ren wbin thr clr  rempty b  g  e  ae l  ack uf
    tbl[0]  = '{1'b0, 4'd0,  4'd2,  1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd5,  4'd2,  1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b0, 4'd2, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b0, 4'd3, 4'd2, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'd5,  4'd2,  1'b0, 1'b0, 4'd3, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b0, 4'd4, 4'd6, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd5,  4'd2,  1'b0, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'd5,  4'd2,  1'b1, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd5,  4'd2,  1'b1, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 4'd5,  4'd2,  1'b0, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 4'd5,  4'd2,  1'b1, 1'b1, 4'd5, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'd13, 4'd7,  1'b0, 1'b0, 4'd5, 4'd7, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd13, 4'd8,  1'b0, 1'b0, 4'd5, 4'd7, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'd13, 4'd15, 1'b0, 1'b0, 4'd6, 4'd5, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'd13, 4'd6,  1'b0, 1'b0, 4'd6, 4'd5, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 4'd7,  4'd0,  1'b0, 1'b0, 4'd6, 4'd5, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 4'd7,  4'd0,  1'b0, 1'b1, 4'd7, 4'd4, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      r_en = tbl[i].ren; g_wptr = gray(tbl[i].wbin); thresh = tbl[i].thr; clr_err = tbl[i].clr;
      #1;
      chk($sformatf("v%0d rempty", i), 32'(rempty), 32'(tbl[i].x_rempty));
      @(negedge clk);
`ifdef RPTR_UNDERFLOW_EN
      uf_exp = tbl[i].x_uf;
`else
      uf_exp = 1'b0;
`endif
      chk($sformatf("v%0d b_rptr", i), 32'(b_rptr), 32'(tbl[i].x_b));
      chk($sformatf("v%0d g_rptr", i), 32'(g_rptr), 32'(tbl[i].x_g));
      chk($sformatf("v%0d raddr", i), 32'(raddr), 32'(tbl[i].x_b[2:0]));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].x_e));
      chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(tbl[i].x_ae));
      chk($sformatf("v%0d rlevel", i), 32'(rlevel), 32'(tbl[i].x_l));
      chk($sformatf("v%0d rd_ack", i), 32'(rd_ack), 32'(tbl[i].x_ack));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(uf_exp));
    end
    r_en = 1'b0; clr_err = 1'b0;

    // Asynchronous reset mid-stream at b_rptr=5, checked before any clock edge.
    do_reset();
    g_wptr = gray(4'd7); thresh = 4'd2;
    @(negedge clk);
    r_en = 1'b1;
    repeat (5) @(negedge clk);
    r_en = 1'b0;
    chk("midstream b_rptr", 32'(b_rptr), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap: 20 entries written and read through an interleaved model.
    g_wptr = '0; thresh = 4'd2;
    @(negedge clk);
    wcnt = '0; rcnt = '0; exp_e = 1'b1; wtotal = 0; seen_wrap = 1'b0;
    for (int step = 0; step < 60; step++) begin
      if (wtotal < 20 && ((wcnt - rcnt) < 4'd8) && (step % 3 != 0)) begin
        wcnt = wcnt + 4'd1;
        wtotal++;
      end
      g_wptr = gray(wcnt);
      r_en   = (step % 4 != 3);
      prev_b = b_rptr; prev_g = g_rptr;
      @(negedge clk);
      if (r_en && !exp_e) rcnt = rcnt + 4'd1;
      lvl   = wcnt - rcnt;
      exp_e = (lvl == 4'd0);
      if (prev_b == 4'd15 && b_rptr == 4'd0 && prev_g == 4'b1000 && g_rptr == 4'b0000)
        seen_wrap = 1'b1;
      chk($sformatf("wrap%0d b_rptr", step), 32'(b_rptr), 32'(rcnt));
      chk($sformatf("wrap%0d g_rptr", step), 32'(g_rptr), 32'(gray(rcnt)));
      chk($sformatf("wrap%0d rlevel", step), 32'(rlevel), 32'(lvl));
      chk($sformatf("wrap%0d empty", step), 32'(empty), 32'(exp_e));
      chk($sformatf("wrap%0d almost_empty", step), 32'(almost_empty), 32'(lvl <= 4'd2));
      chk($sformatf("wrap%0d underflow", step), 32'(underflow), 0);
    end
    r_en = 1'b0;
    chk("wrap_15_to_0_seen", 32'(seen_wrap), 1);
    chk("wrap_total_reads", 32'(rcnt), 32'(20 % 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
